// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with funct3-sized
// load/store access, programmable latency and lane-extracted, extended load data.
//   clk_i, rst_ni (async, active-low)
//   req_valid_i/req_ready_o, req_we_i, req_funct3_i, req_addr_i, req_wdata_i : request channel
//   resp_valid_o/resp_ready_i, resp_rdata_o                                  : response channel
//   resp_err_o : only when DMEM_RESP_ERR_EN is defined (out of range, misaligned, illegal funct3)
module dmem_responder #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_rdata_o
`ifdef DMEM_RESP_ERR_EN
  ,output logic           resp_err_o
`endif
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int AW = $clog2(DEPTH) + OB;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [AW-1:0]     r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_rdata;
  logic [XLEN-1:0]   r_mem [DEPTH];

  logic [1:0]        w_size;
  logic [OB-1:0]     w_amask;
  logic [OB-1:0]     w_off;
  logic [AW-OB-1:0]  w_idx;
  logic [XLEN-1:0]   w_sh;
  logic [XLEN-1:0]   w_ld;
  logic [XLEN-1:0]   w_wd;
  logic [NB-1:0]     w_be;
  logic              w_legal;
  logic              w_ok;

  assign w_size  = r_f3[1:0];
  assign w_amask = OB'((1 << w_size) - 1);
  assign w_off   = r_addr[OB-1:0] & ~w_amask;
  assign w_idx   = r_addr[AW-1:OB];
  assign w_legal = !(r_f3 == 3'b111 || (XLEN == 32 && (r_f3 == 3'b011 || r_f3 == 3'b110)));

`ifdef DMEM_RESP_ERR_EN
  logic r_oor;
  logic r_err;
  assign w_ok       = w_legal && !r_oor && ((r_addr[OB-1:0] & w_amask) == '0);
  assign resp_err_o = r_err;
`else
  // Bits above the array are dropped so addresses wrap silently.
  logic w_unused_addr;
  assign w_unused_addr = ^req_addr_i[XLEN-1:AW];
  assign w_ok          = w_legal;
`endif

  // Lane extraction: shift the selected bytes to bit 0, then extend by size.
  // Casting a signed slice to XLEN sign-extends; full-width sizes pass through.
  assign w_sh = r_mem[w_idx] >> {w_off, 3'b000};
  assign w_ld = (w_size == 2'd0) ? (r_f3[2] ? XLEN'(w_sh[7:0])  : XLEN'($signed(w_sh[7:0]))) :
                (w_size == 2'd1) ? (r_f3[2] ? XLEN'(w_sh[15:0]) : XLEN'($signed(w_sh[15:0]))) :
                (w_size == 2'd2) ? (r_f3[2] ? XLEN'(w_sh[31:0]) : XLEN'($signed(w_sh[31:0]))) :
                w_sh;
  assign w_wd = r_wdata << {w_off, 3'b000};
  assign w_be = NB'((1 << (1 << w_size)) - 1) << w_off;

  assign req_ready_o  = (r_state == IDLE);
  assign resp_valid_o = (r_state == RESP);
  assign resp_rdata_o = r_rdata;

  // WAIT runs LATENCY+1 cycles (counter 0..LATENCY), so resp_valid_o rises
  // LATENCY+2 edges after the accept edge.
  always_comb begin
    w_next = (r_state == IDLE)   ? (req_valid_i ? WAIT : IDLE) :
             (r_state == WAIT)   ? ((r_cnt == 4'(LATENCY)) ? ACCESS : WAIT) :
             (r_state == ACCESS) ? RESP :
             (resp_ready_i ? IDLE : RESP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef DMEM_RESP_ERR_EN
      r_oor   <= 1'b0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == WAIT) ? r_cnt + 4'd1 : 4'd0;
      if (r_state == IDLE && req_valid_i) begin
        r_we    <= req_we_i;
        r_f3    <= req_funct3_i;
        r_addr  <= req_addr_i[AW-1:0];
        r_wdata <= req_wdata_i;
`ifdef DMEM_RESP_ERR_EN
        r_oor   <= |req_addr_i[XLEN-1:AW];
`endif
      end
      if (r_state == ACCESS) begin
        r_rdata <= (!r_we && w_ok) ? w_ld : '0;
`ifdef DMEM_RESP_ERR_EN
        r_err   <= !w_ok;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (r_state == ACCESS && r_we && w_ok)
      for (int b = 0; b < NB; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random checks of dmem_responder against a byte-array model.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic        resp_ready = 1'b0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] rdata;
`ifdef DMEM_RESP_ERR_EN
  logic        err;
`endif
  logic [7:0]  mem_m [1024];
  bit          ref_err;
  int          pass = 0;
  int          total = 0;

  always #5 clk = ~clk;

  dmem_responder #(.XLEN(32), .DEPTH(256), .LATENCY(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_funct3_i(f3), .req_addr_i(addr), .req_wdata_i(wd),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(rdata)
`ifdef DMEM_RESP_ERR_EN
    ,.resp_err_o(err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) pass++;
    else $error("FAIL %s: got %h expected %h", tag, o, e);
  endtask

  // Byte-addressed model: wrap at 1 KiB, align down, extend arithmetically.
  function automatic logic [31:0] ref_op(input logic we_, input logic [2:0] f_,
                                         input logic [31:0] a_, input logic [31:0] d_);
    int n = 1 << f_[1:0];
    bit bad = (f_ == 3'b111) || (f_ == 3'b011) || (f_ == 3'b110);
    int a;
    logic [31:0] v = '0;
`ifdef DMEM_RESP_ERR_EN
    bad = bad || (a_ >= 32'd1024) || ((a_ % n) != 0);
`endif
    ref_err = bad;
    if (bad) return '0;
    a = int'(a_ % 1024);
    a = a - a % n;
    if (we_) begin
      for (int i = 0; i < n; i++) mem_m[a+i] = d_[8*i +: 8];
      return '0;
    end
    for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[a+i];
    if (!f_[2] && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
    return v;
  endfunction

  task automatic xact(input string tag, input logic we_, input logic [2:0] f_,
                      input logic [31:0] a_, input logic [31:0] d_, input int hold,
                      output logic [31:0] rd_o);
    logic [31:0] exp;
    bit exp_err;
    int e;
    exp = ref_op(we_, f_, a_, d_);
    exp_err = ref_err;
    @(negedge clk);
    chk({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we_; f3 = f_; addr = a_; wd = d_;
    @(posedge clk); #1;
    req_valid = 1'b0;
    e = 0;
    while (!resp_valid && e < 20) begin
      @(posedge clk); #1;
      e++;
    end
    chk({tag, ".latency"}, 32'(e), 32'd4);
    rd_o = rdata;
    chk({tag, ".rdata"}, rdata, exp);
`ifdef DMEM_RESP_ERR_EN
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
`else
    chk({tag, ".noerr_model"}, 32'(exp_err && we_ && rdata != 0), 32'd0);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ".hold_rdata"}, rdata, exp);
      chk({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, ".ready_after"}, 32'(req_ready), 32'd1);
    chk({tag, ".valid_after"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int seen;
    #2;
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) xact("fill", 1'b1, 3'b010, 32'(i*4), $urandom, 0, rd);

    xact("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd);
    chk("sw10.zero", rd, 32'h0);
    xact("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 0, rd);
    chk("lw10.const", rd, 32'hDEADBEEF);
    xact("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 0, rd);
    chk("lb13.const", rd, 32'hFFFFFFDE);
    xact("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 0, rd);
    chk("lbu13.const", rd, 32'h000000DE);
    xact("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 0, rd);
    chk("lh12.const", rd, 32'hFFFFDEAD);
    xact("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 0, rd);
    chk("lhu12.const", rd, 32'h0000DEAD);
    xact("sb11", 1'b1, 3'b000, 32'h11, 32'h00000055, 0, rd);
    xact("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 0, rd);
    chk("lw10b.const", rd, 32'hDEAD55EF);
    xact("sh12", 1'b1, 3'b001, 32'h12, 32'h00001234, 0, rd);
    xact("lw10h", 1'b0, 3'b010, 32'h10, 32'h0, 0, rd);
    chk("lw10h.const", rd, 32'h123455EF);
    xact("bp", 1'b0, 3'b010, 32'h10, 32'h0, 5, rd);
    chk("bp.const", rd, 32'h123455EF);

    xact("sw410", 1'b1, 3'b010, 32'h410, 32'h12345678, 0, rd);
    xact("lw10w", 1'b0, 3'b010, 32'h10, 32'h0, 0, rd);
`ifdef DMEM_RESP_ERR_EN
    chk("lw10w.const", rd, 32'h123455EF);
`else
    chk("lw10w.const", rd, 32'h12345678);
`endif
    xact("lw11", 1'b0, 3'b010, 32'h11, 32'h0, 0, rd);
    xact("ill", 1'b1, 3'b111, 32'h10, 32'hFFFFFFFF, 0, rd);
    xact("lw10i", 1'b0, 3'b010, 32'h10, 32'h0, 0, rd);

    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; f3 = 3'b010; addr = 32'h20; wd = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid.valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstmid.ready", 32'(req_ready), 32'd1);
    seen = 0;
    resp_ready = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    resp_ready = 1'b0;
    chk("rstmid.noresp", 32'(seen), 32'd0);
    xact("rstmid.lw20", 1'b0, 3'b010, 32'h20, 32'h0, 0, rd);

    for (int i = 0; i < 300; i++)
      xact("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           32'($urandom_range(0, 2047)), $urandom, int'($urandom_range(0, 2)), rd);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
